// File: rtl/raster_scan_gen.sv
// Raster scan generator: latches one screen-space triangle, clips its bounding
// box to the screen and walks the box row-major at one pixel per cycle,
// honouring a downstream stall without skipping or repeating pixels.
module raster_scan_gen #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tri_valid,
  output logic               o_tri_ready,
  input  logic signed [15:0] i_x0,
  input  logic signed [15:0] i_y0,
  input  logic signed [15:0] i_x1,
  input  logic signed [15:0] i_y1,
  input  logic signed [15:0] i_x2,
  input  logic signed [15:0] i_y2,
  input  logic               i_stall,
  output logic signed [15:0] o_x0,
  output logic signed [15:0] o_y0,
  output logic signed [15:0] o_x1,
  output logic signed [15:0] o_y1,
  output logic signed [15:0] o_x2,
  output logic signed [15:0] o_y2,
  output logic signed [15:0] o_p_x,
  output logic signed [15:0] o_p_y,
  output logic               o_valid,
  output logic               o_last,
  output logic               o_done,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2
  } state_t;

  localparam logic signed [15:0] X_LAST = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] Y_LAST = 16'(SCREEN_H - 1);

  state_t             state_r;
  logic signed [15:0] xmin_r, xmax_r, ymin_r, ymax_r;
  logic signed [15:0] cx_r, cy_r;

  logic signed [15:0] bx_min_s, bx_max_s, by_min_s, by_max_s;
  logic               box_ok_s;
  logic               at_xmax_s;
  logic               at_last_s;

  // Compares are purely signed relational tests, so any S16 vertex is safe.
  function automatic logic signed [15:0] smin2(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [15:0] smax2(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  assign o_tri_ready = (state_r == IDLE);
  assign o_busy      = (state_r != IDLE);

  // Clipped bounding box of the latched vertices, consumed during SETUP.
  always_comb begin
    bx_min_s = smax2(smin2(smin2(o_x0, o_x1), o_x2), 16'sd0);
    bx_max_s = smin2(smax2(smax2(o_x0, o_x1), o_x2), X_LAST);
    by_min_s = smax2(smin2(smin2(o_y0, o_y1), o_y2), 16'sd0);
    by_max_s = smin2(smax2(smax2(o_y0, o_y1), o_y2), Y_LAST);
    box_ok_s = (bx_min_s <= bx_max_s) && (by_min_s <= by_max_s);
  end

  // Cursor position relative to the box corners during SCAN.
  always_comb begin
    at_xmax_s = (cx_r == xmax_r);
    at_last_s = at_xmax_s && (cy_r == ymax_r);
  end

  // Control FSM with registered pixel, qualifier and vertex outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
      xmin_r  <= 16'sd0;
      xmax_r  <= 16'sd0;
      ymin_r  <= 16'sd0;
      ymax_r  <= 16'sd0;
      cx_r    <= 16'sd0;
      cy_r    <= 16'sd0;
      o_x0    <= 16'sd0;
      o_y0    <= 16'sd0;
      o_x1    <= 16'sd0;
      o_y1    <= 16'sd0;
      o_x2    <= 16'sd0;
      o_y2    <= 16'sd0;
      o_p_x   <= 16'sd0;
      o_p_y   <= 16'sd0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state_r)
        IDLE: begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          if (i_tri_valid) begin
            o_x0    <= i_x0;
            o_y0    <= i_y0;
            o_x1    <= i_x1;
            o_y1    <= i_y1;
            o_x2    <= i_x2;
            o_y2    <= i_y2;
            state_r <= SETUP;
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          xmin_r  <= bx_min_s;
          xmax_r  <= bx_max_s;
          ymin_r  <= by_min_s;
          ymax_r  <= by_max_s;
          cx_r    <= bx_min_s;
          cy_r    <= by_min_s;
          if (box_ok_s) begin
            state_r <= SCAN;
          end else begin
            // Entirely off-screen: report completion without any pixels.
            state_r <= IDLE;
            o_done  <= 1'b1;
          end
        end
        SCAN: begin
          if (!i_stall) begin
            o_p_x   <= cx_r;
            o_p_y   <= cy_r;
            o_valid <= 1'b1;
            o_last  <= at_last_s;
            if (at_xmax_s) begin
              cx_r <= xmin_r;
              cy_r <= cy_r + 16'sd1;
            end else begin
              cx_r <= cx_r + 16'sd1;
            end
            if (at_last_s) begin
              state_r <= IDLE;
              o_done  <= 1'b1;
            end else begin
              state_r <= SCAN;
            end
          end else begin
            // Bubble: cursor and pixel registers hold.
            o_valid <= 1'b0;
            o_last  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          o_valid <= 1'b0;
          o_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
